ibar_writeback: RTL and testbench
=================================

IBAR_WRITEBACK -- requirements
Module: ibar_writeback

Interface
REQ-001 SHALL have parameter TAG_W, default 22, meaning line tag width; address = {tag, index[5:0], 4'b0000}.
REQ-002 SHALL have parameter BEATS, default 4, meaning 32-bit write beats per 128-bit line.
REQ-003 clk  in  1  sole clock; all state on rising edge.
REQ-004 rstn  in  1  reset, asynchronous, active-low.
REQ-005 ibar_valid  in  1  dirty-line writeback request from dirty-block scanner; held until ibar_ready.
REQ-006 dirty_addr  in  6  cache index of request.
REQ-007 way0 / way1  in  1 each  way 0 / way 1 dirty at dirty_addr.
REQ-008 ibar_ready  out  1  one-cycle pulse: all dirty ways of current index written back.
REQ-009 rd_en  out  1  cache line read strobe; rd_index out 6; rd_way out 1.
REQ-010 rd_tag  in  TAG_W, rd_data  in  128: valid exactly one cycle after rd_en.
REQ-011 aw_valid out 1, aw_addr out 32, aw_ready in 1: write address handshake.
REQ-012 w_valid out 1, w_data out 32, w_last out 1, w_ready in 1: write data handshake.
REQ-013 b_valid  in  1  write response; b_ready out 1.
REQ-014 busy  out  1  high whenever state != IDLE.

Function
REQ-015 States: IDLE, READ, LATCH, ADDR, DATA, RESP, NEXT, ACK.
REQ-016 IDLE: on ibar_valid, register dirty_addr, way0, way1 into pend[1:0]; -> READ if pend!=0, else -> ACK.
REQ-017 READ: rd_en=1 for one cycle, rd_index=latched index, rd_way = lowest set pend bit (way 0 before way 1); -> LATCH.
REQ-018 LATCH: capture rd_tag/rd_data into line buffer; clear served pend bit; -> ADDR.
REQ-019 ADDR: aw_valid=1, aw_addr={tag,index,4'b0}; transfer when aw_valid&aw_ready; -> DATA.
REQ-020 DATA: beat counter 0..BEATS-1; w_data = line[32*cnt+:32] (beat 0 = bits 31:0); w_last=1 on cnt==BEATS-1; counter advances only on w_valid&w_ready; after last transfer -> RESP.
REQ-021 aw_valid/w_valid, once high, SHALL stay high with stable addr/data until accepted.
REQ-022 RESP: b_ready=1; on b_valid -> NEXT; b_valid in other states ignored.
REQ-023 NEXT: pend!=0 -> READ; else -> ACK.
REQ-024 ACK: ibar_ready=1 exactly one cycle; -> IDLE; ibar_valid ignored in ACK and in first IDLE cycle after ACK.
REQ-025 way0 and way1 both set -> two complete writebacks, way 0 first, single ibar_ready.
REQ-026 way0=way1=0 with ibar_valid -> ibar_ready two cycles after request sampled, no memory traffic.
REQ-027 Changes on dirty_addr/way inputs after IDLE sampling SHALL NOT affect current request.
REQ-028 Latency (zero-wait memory, b_valid next cycle): READ 1 + LATCH 1 + ADDR 1 + DATA 4 + RESP 1 + NEXT 1 per way, + ACK 1.

Reset
REQ-029 rstn low SHALL immediately force IDLE and deassert ibar_ready, rd_en, aw_valid, w_valid, w_last, b_ready, busy; clear pend, beat counter, line buffer.
REQ-030 Reset mid-transfer SHALL abandon the burst without completing it; no ibar_ready issued.

Configuration
REQ-031 Macro IBAR_WB_PERF_EN defined: 16-bit output wb_count increments once per line entering RESP->NEXT, saturates at 16'hFFFF, resets to 0.
REQ-032 IBAR_WB_PERF_EN undefined: wb_count port and counter absent; all other behaviour identical.

Verification
REQ-033 ibar_valid, dirty_addr=6'h05, way0=1, way1=0, rd_tag=22'h0ABCD, ready always 1 -> aw_addr=32'h02AF3450, 4 beats, one ibar_ready pulse.
REQ-034 dirty_addr=6'h3F, way0=way1=1 -> rd_way 0 then 1, two AW + 8 W beats, w_last on beats 4 and 8, single ibar_ready.
REQ-035 way0=way1=0 -> no rd_en/aw_valid, ibar_ready pulses two cycles after request.
REQ-036 w_ready low 3 cycles during beat 2 -> w_data/w_last stable, beat order unchanged, counter not advanced.
REQ-037 rstn low during DATA beat 1 -> outputs deasserted asynchronously; next request processed from READ normally.
REQ-038 IBAR_WB_PERF_EN defined, 3 two-way requests -> wb_count=6.

Source files
------------

// File: rtl/ibar_writeback.sv
// Dirty-line writeback engine: reads up to two dirty ways of one cache index and
// writes each 128-bit line out as an AXI-style AW/W/B burst. Optional IBAR_WB_PERF_EN adds wb_count.
module ibar_writeback #(
    parameter int TAG_W = 22,
    parameter int BEATS = 4
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  ibar_valid,
    input  logic [5:0]            dirty_addr,
    input  logic                  way0,
    input  logic                  way1,
    output logic                  ibar_ready,
    output logic                  rd_en,
    output logic [5:0]            rd_index,
    output logic                  rd_way,
    input  logic [TAG_W-1:0]      rd_tag,
    input  logic [32*BEATS-1:0]   rd_data,
    output logic                  aw_valid,
    output logic [31:0]           aw_addr,
    input  logic                  aw_ready,
    output logic                  w_valid,
    output logic [31:0]           w_data,
    output logic                  w_last,
    input  logic                  w_ready,
    input  logic                  b_valid,
    output logic                  b_ready,
    output logic                  busy,
    output logic [2:0]            fsm_state
`ifdef IBAR_WB_PERF_EN
    ,
    output logic [15:0]           wb_count
`endif
);

    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        LATCH = 3'd2,
        ADDR  = 3'd3,
        DATA  = 3'd4,
        RESP  = 3'd5,
        NEXT  = 3'd6,
        ACK   = 3'd7
    } state_t;

    // Handshakes: a transfer happens on a rising edge where valid and ready are both
    // high; valid and its payload are driven purely from registered state, so they hold until accepted.
    state_t                     state_q, state_d;
    logic [5:0]                 idx_q, idx_d;
    logic [1:0]                 pend_q, pend_d;
    logic                       way_q, way_d;
    logic [TAG_W-1:0]           tag_q, tag_d;
    logic [BEATS-1:0][31:0]     line_q, line_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic                       skip_q, skip_d;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            idx_q   <= '0;
            pend_q  <= '0;
            way_q   <= 1'b0;
            tag_q   <= '0;
            line_q  <= '0;
            cnt_q   <= '0;
            skip_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            pend_q  <= pend_d;
            way_q   <= way_d;
            tag_q   <= tag_d;
            line_q  <= line_d;
            cnt_q   <= cnt_d;
            skip_q  <= skip_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        pend_d     = pend_q;
        way_d      = way_q;
        tag_d      = tag_q;
        line_d     = line_q;
        cnt_d      = cnt_q;
        skip_d     = 1'b0;
        ibar_ready = 1'b0;
        rd_en      = 1'b0;
        rd_way     = 1'b0;
        aw_valid   = 1'b0;
        w_valid    = 1'b0;
        w_last     = 1'b0;
        b_ready    = 1'b0;
        case (state_q)
            IDLE: begin
                // skip_q masks the still-held request during the cycle right after ACK
                if (ibar_valid && !skip_q) begin
                    idx_d   = dirty_addr;
                    pend_d  = {way1, way0};
                    state_d = (way0 || way1) ? READ : ACK;
                end
            end
            READ: begin
                rd_en   = 1'b1;
                rd_way  = ~pend_q[0];
                way_d   = ~pend_q[0];
                state_d = LATCH;
            end
            LATCH: begin
                tag_d         = rd_tag;
                line_d        = rd_data;
                pend_d[way_q] = 1'b0;
                cnt_d         = '0;
                state_d       = ADDR;
            end
            ADDR: begin
                aw_valid = 1'b1;
                if (aw_ready) state_d = DATA;
            end
            DATA: begin
                w_valid = 1'b1;
                w_last  = (cnt_q == LAST_BEAT);
                if (w_ready) begin
                    if (cnt_q == LAST_BEAT) begin
                        cnt_d   = '0;
                        state_d = RESP;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            RESP: begin
                b_ready = 1'b1;
                if (b_valid) state_d = NEXT;
            end
            NEXT: begin
                state_d = (pend_q != 2'b00) ? READ : ACK;
            end
            ACK: begin
                ibar_ready = 1'b1;
                skip_d     = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign rd_index  = idx_q;
    assign aw_addr   = 32'({tag_q, idx_q, 4'b0000});
    assign w_data    = line_q[cnt_q];
    assign busy      = (state_q != IDLE);
    assign fsm_state = state_q;

`ifdef IBAR_WB_PERF_EN
    logic [15:0] wb_count_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wb_count_q <= '0;
        end else if (state_q == RESP && b_valid && wb_count_q != 16'hFFFF) begin
            wb_count_q <= wb_count_q + 16'd1;
        end
    end

    assign wb_count = wb_count_q;
`endif

endmodule

// File: tb/tb_ibar_writeback.sv
// Scoreboard bench for ibar_writeback: a line memory model answers reads, expected
// read requests, AW addresses and W beats are queued per request and popped on handshakes.
module tb_ibar_writeback;

    localparam int TAG_W = 22;
    localparam int BEATS = 4;

    logic               clk = 1'b0;
    logic               rstn;
    logic               ibar_valid;
    logic [5:0]         dirty_addr;
    logic               way0, way1;
    logic               ibar_ready;
    logic               rd_en;
    logic [5:0]         rd_index;
    logic               rd_way;
    logic [TAG_W-1:0]   rd_tag;
    logic [127:0]       rd_data;
    logic               aw_valid;
    logic [31:0]        aw_addr;
    logic               aw_ready;
    logic               w_valid;
    logic [31:0]        w_data;
    logic               w_last;
    logic               w_ready;
    logic               b_valid;
    logic               b_ready;
    logic               busy;
    logic [2:0]         fsm_state;
`ifdef IBAR_WB_PERF_EN
    logic [15:0]        wb_count;
`endif

    ibar_writeback #(.TAG_W(TAG_W), .BEATS(BEATS)) dut (
        .clk(clk), .rstn(rstn),
        .ibar_valid(ibar_valid), .dirty_addr(dirty_addr), .way0(way0), .way1(way1),
        .ibar_ready(ibar_ready),
        .rd_en(rd_en), .rd_index(rd_index), .rd_way(rd_way),
        .rd_tag(rd_tag), .rd_data(rd_data),
        .aw_valid(aw_valid), .aw_addr(aw_addr), .aw_ready(aw_ready),
        .w_valid(w_valid), .w_data(w_data), .w_last(w_last), .w_ready(w_ready),
        .b_valid(b_valid), .b_ready(b_ready),
        .busy(busy), .fsm_state(fsm_state)
`ifdef IBAR_WB_PERF_EN
        , .wb_count(wb_count)
`endif
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    int           n_vec = 0;
    int           n_miss = 0;
    int           beats_seen = 0;
    int           lines_exp = 0;
    bit           rand_ready = 1'b0;
    logic [6:0]   exp_rd_q[$];
    logic [31:0]  exp_aw_q[$];
    logic [32:0]  exp_w_q[$];
    logic [TAG_W-1:0] tag_mem[128];
    logic [127:0]     data_mem[128];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Line memory: tag/data appear the cycle after the read strobe.
    always @(posedge clk) begin
        if (rd_en) begin
            rd_tag  <= tag_mem[{rd_index, rd_way}];
            rd_data <= data_mem[{rd_index, rd_way}];
        end
    end

    // Random back-pressure on the memory side.
    always @(posedge clk) begin
        if (rand_ready) begin
            #1;
            aw_ready = 1'($urandom_range(0, 1));
            w_ready  = 1'($urandom_range(0, 1));
            b_valid  = 1'($urandom_range(0, 1));
        end
    end

    // Monitor: sampled on the falling edge, handshakes complete on the next rising edge.
    always @(negedge clk) begin
        if (rstn) begin
            if (rd_en) begin
                if (exp_rd_q.size() > 0) check_eq("rd_req", {rd_index, rd_way}, exp_rd_q.pop_front());
                else check_eq("rd_unexpected", exp_rd_q.size(), 1);
            end
            if (aw_valid && aw_ready) begin
                if (exp_aw_q.size() > 0) check_eq("aw_addr", aw_addr, exp_aw_q.pop_front());
                else check_eq("aw_unexpected", exp_aw_q.size(), 1);
            end
            if (w_valid && w_ready) begin
                beats_seen++;
                if (exp_w_q.size() > 0) check_eq("w_beat", {w_last, w_data}, exp_w_q.pop_front());
                else check_eq("w_unexpected", exp_w_q.size(), 1);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic push_expect(input logic [5:0] idx, input logic w0, input logic w1);
        logic [6:0] k;
        beats_seen = 0;
        for (int w = 0; w < 2; w++) begin
            if ((w == 0 && w0) || (w == 1 && w1)) begin
                k = {idx, w[0]};
                exp_rd_q.push_back(k);
                exp_aw_q.push_back({tag_mem[k], idx, 4'b0000});
                for (int b = 0; b < BEATS; b++)
                    exp_w_q.push_back({(b == BEATS - 1), data_mem[k][32*b +: 32]});
                lines_exp++;
            end
        end
    endtask

    // Latency = cycles from the IDLE cycle that samples the request to the ibar_ready cycle, inclusive.
    task automatic run_req(input logic [5:0] idx, input logic w0, input logic w1, input int exp_lat);
        int n;
        push_expect(idx, w0, w1);
        @(posedge clk); #1;
        ibar_valid = 1'b1; dirty_addr = idx; way0 = w0; way1 = w1;
        @(posedge clk); #1;
        dirty_addr = 6'($urandom); way0 = 1'($urandom_range(0, 1)); way1 = 1'($urandom_range(0, 1));
        check_eq("busy_after_sample", busy, 1);
        n = 2;
        while (!ibar_ready && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq("ack_seen", ibar_ready, 1);
        if (exp_lat > 0) check_eq("latency", n, exp_lat);
        // keep the request up through ACK and the next IDLE cycle; it must be ignored
        @(posedge clk); #1;
        check_eq("ack_one_cycle", ibar_ready, 0);
        check_eq("idle_after_ack", busy, 0);
        ibar_valid = 1'b0;
        @(posedge clk); #1;
        check_eq("no_restart", busy, 0);
        check_eq("sb_drained", exp_rd_q.size() + exp_aw_q.size() + exp_w_q.size(), 0);
`ifdef IBAR_WB_PERF_EN
        check_eq("wb_count", wb_count, lines_exp);
`endif
    endtask

    task automatic stall_beat2();
        int n = 0;
        while (!(w_valid && beats_seen == 2) && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq("stall_reached", w_valid && beats_seen == 2, 1);
        w_ready = 1'b0;
        repeat (3) begin
            check_eq("stall_data", w_data, exp_w_q[0][31:0]);
            check_eq("stall_last", w_last, 0);
            @(posedge clk); #1;
        end
        w_ready = 1'b1;
    endtask

    task automatic reset_mid_data();
        int n = 0;
        push_expect(6'h21, 1'b1, 1'b0);
        @(posedge clk); #1;
        ibar_valid = 1'b1; dirty_addr = 6'h21; way0 = 1'b1; way1 = 1'b0;
        while (!(w_valid && beats_seen == 1) && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq("rst_beat1_reached", w_valid && beats_seen == 1, 1);
        #2 rstn = 1'b0;
        #1;
        check_eq("rst_async_w_valid", w_valid, 0);
        check_eq("rst_async_w_last", w_last, 0);
        check_eq("rst_async_busy", busy, 0);
        check_eq("rst_async_state", fsm_state, 0);
        ibar_valid = 1'b0;
        exp_rd_q.delete(); exp_aw_q.delete(); exp_w_q.delete();
        lines_exp = 0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_no_ack", ibar_ready, 0);
        check_eq("rst_hold_aw", aw_valid, 0);
        rstn = 1'b1;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        rstn = 1'b0; ibar_valid = 1'b0; dirty_addr = '0; way0 = 1'b0; way1 = 1'b0;
        aw_ready = 1'b1; w_ready = 1'b1; b_valid = 1'b1;
        rd_tag = '0; rd_data = '0;
        for (int i = 0; i < 128; i++) begin
            tag_mem[i]  = 22'($urandom);
            data_mem[i] = {$urandom(), $urandom(), $urandom(), $urandom()};
        end
        tag_mem[{6'h05, 1'b0}] = 22'h0ABCD;

        repeat (2) @(posedge clk);
        #1;
        check_eq("reset_ibar_ready", ibar_ready, 0);
        check_eq("reset_rd_en", rd_en, 0);
        check_eq("reset_aw_valid", aw_valid, 0);
        check_eq("reset_w_valid", w_valid, 0);
        check_eq("reset_w_last", w_last, 0);
        check_eq("reset_b_ready", b_ready, 0);
        check_eq("reset_busy", busy, 0);
        check_eq("reset_state", fsm_state, 0);
`ifdef IBAR_WB_PERF_EN
        check_eq("reset_wb_count", wb_count, 0);
`endif
        rstn = 1'b1;

        // single dirty way, aw_addr 32'h02AF3450
        run_req(6'h05, 1'b1, 1'b0, 11);
        // both ways at the top index: way 0 then way 1, single ack
        run_req(6'h3F, 1'b1, 1'b1, 20);
        // nothing dirty: no traffic, ack in the second cycle
        run_req(6'h0A, 1'b0, 1'b0, 2);
        // way 1 only
        run_req(6'h11, 1'b0, 1'b1, 11);

        // write-data back-pressure during beat 2
        beats_seen = 0;
        fork
            run_req(6'h12, 1'b1, 1'b0, 14);
            stall_beat2();
        join

        // random indices/ways with random ready/response timing
        rand_ready = 1'b1;
        for (int i = 0; i < 8; i++)
            run_req(6'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1);
        rand_ready = 1'b0;
        @(posedge clk); #2;
        aw_ready = 1'b1; w_ready = 1'b1; b_valid = 1'b1;

        // reset in the middle of a burst, then three two-way requests
        reset_mid_data();
        run_req(6'h21, 1'b1, 1'b1, 20);
        run_req(6'h22, 1'b1, 1'b1, 20);
        run_req(6'h23, 1'b1, 1'b1, 20);
`ifdef IBAR_WB_PERF_EN
        check_eq("wb_count_six", wb_count, 6);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
